// File: rtl/bcd_to_binary_converter_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_to_binary_converter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_e;

    // A digit field at or above this after a right shift came from a
    // doubled weight and needs the correction subtracted.
    localparam logic [3:0] CORR_THRESHOLD = 4'd8;
    localparam logic [3:0] CORR_VALUE     = 4'd3;

    // Width of an iteration counter able to hold 0..bin_width inclusive.
    function automatic int count_width(input int bin_width);
        return $clog2(bin_width + 1);
    endfunction

endpackage

// File: rtl/bcd_to_binary_converter_bcd_digit_corrector.sv
// Single-digit reverse double-dabble correction: subtract 3 from fields >= 8.
module bcd_digit_corrector
    import bcd_to_binary_converter_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Purely combinational correction; cannot underflow since input >= 8.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= CORR_THRESHOLD) begin
            digit_out = digit_in - CORR_VALUE;
        end
    end

endmodule

// File: rtl/bcd_to_binary_converter.sv
// Sequential reverse double-dabble converter: packed BCD in, unsigned binary out.
module bcd_to_binary_converter
    import bcd_to_binary_converter_pkg::*;
#(
    parameter int DIGITS    = 3,
    parameter int BIN_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_conversion,
    input  logic [4*DIGITS-1:0]   bcd_data,
    output logic                  end_of_conversion,
    output logic [BIN_WIDTH-1:0]  binary_data,
    output logic                  invalid_bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_WIDTH;
    localparam int CNT_W = count_width(BIN_WIDTH);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIN_WIDTH);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [SR_W-1:0]        shift_q, shift_d;
    logic [BIN_WIDTH-1:0]   binary_q, binary_d;
    logic                   eoc_q, eoc_d;
    logic                   invalid_q, invalid_d;

    logic [SR_W-1:0]        shifted;
    logic [BCD_W-1:0]       corrected_bcd;
    logic [SR_W-1:0]        stepped;
    logic                   bcd_bad;

    assign shifted = shift_q >> 1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_corrector u_corr (
                .digit_in  (shifted[BIN_WIDTH + 4*g +: 4]),
                .digit_out (corrected_bcd[4*g +: 4])
            );
        end
    endgenerate

    assign stepped = {corrected_bcd, shifted[BIN_WIDTH-1:0]};

    // Flag any input nibble outside 0..9.
    always_comb begin
        bcd_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_data[4*i +: 4] > 4'd9) begin
                bcd_bad = 1'b1;
            end
        end
    end

    // Next-state and output logic for the IDLE/CONVERT controller.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shift_d   = shift_q;
        binary_d  = binary_q;
        eoc_d     = 1'b0;
        invalid_d = invalid_q;
        case (state_q)
            IDLE: begin
                if (start_conversion) begin
                    if (bcd_bad) begin
                        eoc_d     = 1'b1;
                        invalid_d = 1'b1;
                    end else begin
                        shift_d = {bcd_data, {BIN_WIDTH{1'b0}}};
                        count_d = '0;
                        state_d = CONVERT;
                    end
                end
            end
            CONVERT: begin
                if (count_q == LAST_COUNT) begin
                    binary_d  = shift_q[BIN_WIDTH-1:0];
                    eoc_d     = 1'b1;
                    invalid_d = 1'b0;
                    count_d   = '0;
                    shift_d   = '0;
                    state_d   = IDLE;
                end else begin
                    shift_d = stepped;
                    count_d = count_q + 1'b1;
                end
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            shift_q   <= '0;
            binary_q  <= '0;
            eoc_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            binary_q  <= binary_d;
            eoc_q     <= eoc_d;
            invalid_q <= invalid_d;
        end
    end

    assign end_of_conversion = eoc_q;
    assign binary_data       = binary_q;
    assign invalid_bcd       = invalid_q;

endmodule
